clock_sched: RTL and testbench
==============================

CLOCK_SCHED -- requirements
Module: clock_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of clock-enable channels.
REQ-002 SHALL have parameter DIV_W, default 8: divisor width.
REQ-003 SHALL have parameter CNT_W, default 64: cycle-counter width.
REQ-004 SHALL have parameter DIVS, packed NUM_CH x DIV_W, default {24,12,4}: per-channel divisor, channel 0 in the LSBs.
REQ-005 SHALL have parameter STEP_CH, default 1: channel that defines one single-step.
REQ-006 SHALL have parameter RUN_AT_RESET, default 1: state entered on reset release (1 = RUN, 0 = HALT).
REQ-007 SHALL have port clock, input, 1: the only clock.
REQ-008 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-009 SHALL have port run, input, 1: level request to free-run.
REQ-010 SHALL have port step_req, input, 1: single-clock pulse requesting one STEP_CH enable.
REQ-011 SHALL have port stall, input, NUM_CH: per-channel suspend (DMA-style).
REQ-012 SHALL have port bp_en, input, 1: breakpoint enable.
REQ-013 SHALL have port bp_ch, input, $clog2(NUM_CH): breakpoint channel.
REQ-014 SHALL have port bp_value, input, CNT_W: breakpoint cycle value.
REQ-015 SHALL have port clk_en, output, NUM_CH: raw divided enable, one clock wide.
REQ-016 SHALL have port clk_en_gated, output, NUM_CH: clk_en & ~stall.
REQ-017 SHALL have port cycle, output, NUM_CH*CNT_W: flattened per-channel cycle counts, channel 0 in the LSBs.
REQ-018 SHALL have port parity, output, NUM_CH: cycle[i] bit 0.
REQ-019 SHALL have port running, output, 1: high in RUN or STEP.
REQ-020 SHALL have port bp_hit, output, 1: sticky breakpoint flag.

Function
REQ-021 Each channel SHALL keep a prescaler counting 0..DIV-1, advancing only on clocks where running=1.
REQ-022 clk_en[i] SHALL be combinationally high exactly while prescaler[i]==DIV-1 and running=1, so the first enable occurs on the DIV-th running clock after reset release.
REQ-023 A divisor of 0 or 1 SHALL yield clk_en[i] high on every running clock.
REQ-024 All prescalers SHALL start from 0 together, so channels with commensurate divisors assert coincident enables (e.g. ch1 and ch2 at every 24th clock).
REQ-025 cycle[i] SHALL increment by 1 on each clock where clk_en_gated[i]=1 and SHALL wrap modulo 2^CNT_W.
REQ-026 stall[i] SHALL NOT affect prescaler[i] or clk_en[i]; it SHALL only suppress clk_en_gated[i] and the cycle[i] increment.
REQ-027 The FSM SHALL have states HALT, RUN and STEP.
REQ-028 FSM transition HALT->RUN SHALL occur when run=1 and bp_hit=0.
REQ-029 FSM transition RUN->HALT SHALL occur when run=0 or on a breakpoint match.
REQ-030 FSM transition HALT->STEP SHALL occur on step_req=1 with run=0.
REQ-031 FSM transition STEP->HALT SHALL occur on the clock on which clk_en[STEP_CH]=1, or on a breakpoint match.
REQ-032 step_req SHALL be ignored in RUN and STEP.
REQ-033 A breakpoint match SHALL be: bp_en=1, and cycle[bp_ch] is incremented this clock to a value equal to bp_value.
REQ-034 On a breakpoint match the enable of that clock SHALL still be issued, bp_hit SHALL be set, and the FSM SHALL be in HALT on the next clock.
REQ-035 An unchanged counter (stall or halt) SHALL never produce a breakpoint match.
REQ-036 bp_hit SHALL clear only on a clock in HALT with run=0; resuming therefore requires run to be dropped then raised.
REQ-037 When a breakpoint match and run=0 occur on the same clock, the result SHALL be HALT with bp_hit set.
REQ-038 An out-of-range bp_ch SHALL disable breakpoint matching.

Reset
REQ-039 On reset assertion all prescalers and all cycle counters SHALL be 0.
REQ-040 On reset assertion bp_hit SHALL be 0.
REQ-041 On reset assertion clk_en, clk_en_gated and parity SHALL be 0.
REQ-042 On reset assertion the FSM SHALL be RUN if RUN_AT_RESET=1, else HALT.
REQ-043 A reset asserted mid-STEP or mid-count SHALL abort that operation with no enable pulse emitted afterwards until the reset-release count of REQ-022 elapses.

Structure
REQ-044 Package nes_clk_pkg SHALL hold the sched_state_t enum (HALT, RUN, STEP) and the default divisor constants (PPU_DIV=4, CPU_DIV=12, APU_DIV=24).
REQ-045 Sub-module clk_chan SHALL implement one channel (prescaler, enable, gating, counter, match compare); clock_sched SHALL instantiate NUM_CH copies via generate, plus the FSM.

Verification
REQ-046 Scenario: defaults, reset released, run=1 for 48 clocks -> clk_en[0] 12 pulses, clk_en[1] 4, clk_en[2] 2; cycle = {2,4,12}; ch1 and ch2 coincide at clocks 24 and 48.
REQ-047 Scenario: stall[1]=1 for clocks 13-36 -> clk_en[1] pulses at 24 and 36, clk_en_gated[1] none; cycle[1]=1 at clock 36; parity[1]=1.
REQ-048 Scenario: bp_en=1, bp_ch=1, bp_value=5 -> 5th ch1 enable at clock 60 issued, bp_hit=1, running=0 from clock 61; holding run=1 stays halted; run 0 then 1 resumes with bp_hit=0.
REQ-049 Scenario: HALT (RUN_AT_RESET=0), step_req pulse -> exactly one clk_en[1] after 12 clocks, cycle[1]=1, back in HALT; second pulse sent during STEP ignored.
REQ-050 Scenario: CNT_W=4, DIVS={1,1,1}, run 16 clocks -> cycle wraps 15->0; parity toggles every clock.
REQ-051 Scenario: reset asserted at clock 7 of a STEP -> all outputs 0 immediately; next ch1 enable 12 clocks after release.

Source files
------------

// File: rtl/nes_clk_pkg.sv
// Shared types and default divisors for the clock-enable scheduler.
package nes_clk_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } sched_state_t;

    localparam int PPU_DIV = 4;
    localparam int CPU_DIV = 12;
    localparam int APU_DIV = 24;

endpackage

// File: rtl/clk_chan.sv
// One scheduler channel: prescaler, divided enable, stall gating,
// cycle counter and breakpoint compare.
module clk_chan #(
    parameter int               DIV_W = 8,
    parameter int               CNT_W = 64,
    parameter logic [DIV_W-1:0] DIV   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             running,
    input  logic             stall,
    input  logic             bp_sel,
    input  logic [CNT_W-1:0] bp_value,
    output logic             clk_en,
    output logic             clk_en_gated,
    output logic [CNT_W-1:0] cycle,
    output logic             parity,
    output logic             match
);

    // Divisors of 0 and 1 both mean "every running clock".
    localparam logic [DIV_W-1:0] LAST = (DIV > 1) ? DIV - 1'b1 : '0;

    logic [DIV_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        clk_en       = running && (pre_q == LAST);
        clk_en_gated = clk_en && !stall;
        pre_d        = pre_q;
        if (running) begin
            pre_d = clk_en ? '0 : pre_q + 1'b1;
        end
        cnt_d = clk_en_gated ? cnt_q + 1'b1 : cnt_q;
        match = bp_sel && clk_en_gated && (cnt_d == bp_value);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    assign cycle  = cnt_q;
    assign parity = cnt_q[0];

endmodule

// File: rtl/clock_sched.sv
// Multi-channel clock-enable scheduler with run/halt/single-step
// control and a sticky cycle breakpoint.
module clock_sched
    import nes_clk_pkg::*;
#(
    parameter int                      NUM_CH       = 3,
    parameter int                      DIV_W        = 8,
    parameter int                      CNT_W        = 64,
    parameter logic [NUM_CH*DIV_W-1:0] DIVS         = {DIV_W'(APU_DIV),
                                                       DIV_W'(CPU_DIV),
                                                       DIV_W'(PPU_DIV)},
    parameter int                      STEP_CH      = 1,
    parameter bit                      RUN_AT_RESET = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       step_req,
    input  logic [NUM_CH-1:0]          stall,
    input  logic                       bp_en,
    input  logic [$clog2(NUM_CH)-1:0]  bp_ch,
    input  logic [CNT_W-1:0]           bp_value,
    output logic [NUM_CH-1:0]          clk_en,
    output logic [NUM_CH-1:0]          clk_en_gated,
    output logic [NUM_CH*CNT_W-1:0]    cycle,
    output logic [NUM_CH-1:0]          parity,
    output logic                       running,
    output logic                       bp_hit
);

    localparam int BP_W = $clog2(NUM_CH);

    sched_state_t      state_q, state_d;
    logic              bp_hit_q, bp_hit_d;
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] match;
    logic              hit;

    // Reset forces running low so no enable leaks while it is held.
    assign running = !reset && (state_q != HALT);
    assign hit     = |match;
    assign bp_hit  = bp_hit_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range bp_ch selects no channel.
        assign sel[i] = bp_en && (bp_ch == BP_W'(i));

        clk_chan #(
            .DIV_W (DIV_W),
            .CNT_W (CNT_W),
            .DIV   (DIVS[i*DIV_W +: DIV_W])
        ) u_chan (
            .clock        (clock),
            .reset        (reset),
            .running      (running),
            .stall        (stall[i]),
            .bp_sel       (sel[i]),
            .bp_value     (bp_value),
            .clk_en       (clk_en[i]),
            .clk_en_gated (clk_en_gated[i]),
            .cycle        (cycle[i*CNT_W +: CNT_W]),
            .parity       (parity[i]),
            .match        (match[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        bp_hit_d = bp_hit_q;
        unique case (state_q)
            HALT: begin
                if (run && !bp_hit_q) begin
                    state_d = RUN;
                end else if (step_req && !run) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (!run || hit) begin
                    state_d = HALT;
                end
            end
            STEP: begin
                if (clk_en[STEP_CH] || hit) begin
                    state_d = HALT;
                end
            end
            default: state_d = HALT;
        endcase
        if (hit) begin
            bp_hit_d = 1'b1;
        end else if (state_q == HALT && !run) begin
            bp_hit_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= RUN_AT_RESET ? RUN : HALT;
            bp_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bp_hit_q <= bp_hit_d;
        end
    end

endmodule

// File: tb/tb_clock_sched.sv
// Scoreboard bench for clock_sched: three instances cover the
// default, halt-at-reset and narrow-counter configurations.
module tb_clock_sched;

    typedef struct {
        int         clk;
        logic [2:0] en;
        logic [2:0] eng;
    } ev_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_run  = 0;
    int n_fail = 0;

    ev_t q_a[$];
    ev_t q_h[$];
    ev_t mev_a, mev_h;

    // Instance A: defaults
    logic         rst_a = 1'b1, run_a = 1'b0, step_a = 1'b0;
    logic [2:0]   stall_a = '0;
    logic         bp_en_a = 1'b0;
    logic [1:0]   bp_ch_a = '0;
    logic [63:0]  bp_val_a = '0;
    logic [2:0]   en_a, eng_a, par_a;
    logic [191:0] cyc_a;
    logic         running_a, hit_a;

    // Instance H: halted at reset
    logic         rst_h = 1'b1, run_h = 1'b0, step_h = 1'b0;
    logic [2:0]   stall_h = '0;
    logic         bp_en_h = 1'b0;
    logic [1:0]   bp_ch_h = '0;
    logic [63:0]  bp_val_h = '0;
    logic [2:0]   en_h, eng_h, par_h;
    logic [191:0] cyc_h;
    logic         running_h, hit_h;

    // Instance W: 4-bit counters, divisors 0/1
    logic         rst_w = 1'b1, run_w = 1'b0, step_w = 1'b0;
    logic [2:0]   stall_w = '0;
    logic         bp_en_w = 1'b0;
    logic [1:0]   bp_ch_w = '0;
    logic [3:0]   bp_val_w = '0;
    logic [2:0]   en_w, eng_w, par_w;
    logic [11:0]  cyc_w;
    logic         running_w, hit_w;

    clock_sched dut_a (
        .clock(clock), .reset(rst_a), .run(run_a), .step_req(step_a),
        .stall(stall_a), .bp_en(bp_en_a), .bp_ch(bp_ch_a),
        .bp_value(bp_val_a), .clk_en(en_a), .clk_en_gated(eng_a),
        .cycle(cyc_a), .parity(par_a), .running(running_a),
        .bp_hit(hit_a)
    );

    clock_sched #(.RUN_AT_RESET(1'b0)) dut_h (
        .clock(clock), .reset(rst_h), .run(run_h), .step_req(step_h),
        .stall(stall_h), .bp_en(bp_en_h), .bp_ch(bp_ch_h),
        .bp_value(bp_val_h), .clk_en(en_h), .clk_en_gated(eng_h),
        .cycle(cyc_h), .parity(par_h), .running(running_h),
        .bp_hit(hit_h)
    );

    clock_sched #(.CNT_W(4), .DIVS({8'd0, 8'd1, 8'd1})) dut_w (
        .clock(clock), .reset(rst_w), .run(run_w), .step_req(step_w),
        .stall(stall_w), .bp_en(bp_en_w), .bp_ch(bp_ch_w),
        .bp_value(bp_val_w), .clk_en(en_w), .clk_en_gated(eng_w),
        .cycle(cyc_w), .parity(par_w), .running(running_w),
        .bp_hit(hit_w)
    );

    // Clocks since reset release, per instance
    int clk_a = 0, clk_h = 0;
    always @(posedge clock or posedge rst_a)
        if (rst_a) clk_a <= 0; else clk_a <= clk_a + 1;
    always @(posedge clock or posedge rst_h)
        if (rst_h) clk_h <= 0; else clk_h <= clk_h + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic ev_t mk(input int c, input logic [2:0] en,
                               input logic [2:0] eng);
        ev_t e;
        e.clk = c;
        e.en  = en;
        e.eng = eng;
        return e;
    endfunction

    // Default divisors 4/12/24; ch1 gated off within [s0,s1]
    task automatic push_a(input int k0, input int k1,
                          input int s0, input int s1);
        ev_t e;
        for (int k = k0; k <= k1; k++) begin
            e.clk = k;
            e.en  = {k % 24 == 0, k % 12 == 0, k % 4 == 0};
            e.eng = e.en & ((k >= s0 && k <= s1) ? 3'b101 : 3'b111);
            if (e.en != 3'b000) q_a.push_back(e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (!rst_a && en_a != 3'b000) begin
            if (q_a.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL mon_a: unexpected clk_en=%b at clock %0d",
                         en_a, clk_a + 1);
            end else begin
                mev_a = q_a.pop_front();
                chk("mon_a_clock", 64'(clk_a + 1), 64'(mev_a.clk));
                chk("mon_a_en", en_a, mev_a.en);
                chk("mon_a_gated", eng_a, mev_a.eng);
            end
        end
    end

    always @(negedge clock) begin
        if (!rst_h && en_h != 3'b000) begin
            if (q_h.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL mon_h: unexpected clk_en=%b at clock %0d",
                         en_h, clk_h + 1);
            end else begin
                mev_h = q_h.pop_front();
                chk("mon_h_clock", 64'(clk_h + 1), 64'(mev_h.clk));
                chk("mon_h_en", en_h, mev_h.en);
                chk("mon_h_gated", eng_h, mev_h.eng);
            end
        end
    end

    initial begin
        tick(2);
        chk("rst_en", en_a, 0);
        chk("rst_gated", eng_a, 0);
        chk("rst_cycle", 64'(|cyc_a), 0);
        chk("rst_parity", par_a, 0);
        chk("rst_hit", hit_a, 0);
        chk("rst_w_en", en_w, 0);

        // Free run 48 clocks
        push_a(1, 48, 0, 0);
        run_a = 1'b1;
        rst_a = 1'b0;
        tick(48);
        run_a = 1'b0;
        tick(1);
        chk("s1_cyc0", cyc_a[63:0], 12);
        chk("s1_cyc1", cyc_a[127:64], 4);
        chk("s1_cyc2", cyc_a[191:128], 2);
        chk("s1_halted", running_a, 0);
        chk("s1_q_empty", q_a.size(), 0);

        // Stall ch1 over clocks 13..36
        rst_a = 1'b1;
        tick(1);
        push_a(1, 48, 13, 36);
        run_a = 1'b1;
        rst_a = 1'b0;
        tick(12);
        stall_a = 3'b010;
        tick(24);
        chk("s2_cyc1_at36", cyc_a[127:64], 1);
        chk("s2_par1", par_a[1], 1);
        stall_a = 3'b000;
        tick(12);
        run_a = 1'b0;
        tick(1);
        chk("s2_cyc1_end", cyc_a[127:64], 2);
        chk("s2_q_empty", q_a.size(), 0);

        // Breakpoint on 5th ch1 enable
        rst_a = 1'b1;
        tick(1);
        bp_en_a  = 1'b1;
        bp_ch_a  = 2'd1;
        bp_val_a = 64'd5;
        push_a(1, 60, 0, 0);
        run_a = 1'b1;
        rst_a = 1'b0;
        tick(60);
        chk("s3_hit", hit_a, 1);
        chk("s3_halted", running_a, 0);
        chk("s3_cyc1", cyc_a[127:64], 5);
        tick(10);
        chk("s3_hold_halted", running_a, 0);
        chk("s3_hold_hit", hit_a, 1);
        run_a = 1'b0;
        tick(1);
        chk("s3_hit_clear", hit_a, 0);
        run_a = 1'b1;
        tick(1);
        chk("s3_resumed", running_a, 1);
        chk("s3_resume_hit", hit_a, 0);
        tick(2);
        run_a = 1'b0;
        tick(1);
        chk("s3_stop", running_a, 0);
        chk("s3_q_empty", q_a.size(), 0);
        bp_en_a = 1'b0;

        // Reset during a step, then free run from release
        rst_a = 1'b1;
        tick(1);
        q_a.push_back(mk(5, 3'b001, 3'b001));
        rst_a = 1'b0;
        tick(1);
        step_a = 1'b1;
        tick(1);
        step_a = 1'b0;
        chk("s6_stepping", running_a, 1);
        tick(6);
        rst_a = 1'b1;
        #1;
        chk("s6_rst_en", en_a, 0);
        chk("s6_rst_gated", eng_a, 0);
        chk("s6_rst_cycle", 64'(|cyc_a), 0);
        chk("s6_rst_parity", par_a, 0);
        chk("s6_rst_running", running_a, 0);
        tick(2);
        q_a.push_back(mk(4, 3'b001, 3'b001));
        q_a.push_back(mk(8, 3'b001, 3'b001));
        q_a.push_back(mk(12, 3'b011, 3'b011));
        run_a = 1'b1;
        rst_a = 1'b0;
        tick(12);
        run_a = 1'b0;
        tick(1);
        chk("s6_cyc1", cyc_a[127:64], 1);
        chk("s6_q_empty", q_a.size(), 0);

        // Single step from HALT; second request ignored
        rst_h = 1'b0;
        tick(3);
        chk("s4_idle", running_h, 0);
        q_h.push_back(mk(8, 3'b001, 3'b001));
        q_h.push_back(mk(12, 3'b001, 3'b001));
        q_h.push_back(mk(16, 3'b011, 3'b011));
        step_h = 1'b1;
        tick(1);
        step_h = 1'b0;
        tick(5);
        step_h = 1'b1;
        tick(1);
        step_h = 1'b0;
        tick(6);
        chk("s4_halted", running_h, 0);
        chk("s4_cyc1", cyc_h[127:64], 1);
        chk("s4_cyc0", cyc_h[63:0], 3);
        tick(10);
        chk("s4_still_halted", running_h, 0);
        chk("s4_q_empty", q_h.size(), 0);

        // 4-bit wrap, divisors 0/1, out-of-range breakpoint channel
        bp_en_w  = 1'b1;
        bp_ch_w  = 2'd3;
        bp_val_w = 4'd5;
        run_w = 1'b1;
        rst_w = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            chk("s5_cycle", cyc_w, {3{4'(k)}});
            chk("s5_parity", par_w, {3{k[0]}});
        end
        chk("s5_wrapped", cyc_w[3:0], 0);
        chk("s5_running", running_w, 1);
        chk("s5_no_hit", hit_w, 0);
        run_w = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
